// File: rtl/cmd_phy_serdes_if.sv
// cmd_phy_serdes_if: command/response handshake between CMD control and the CMD-line PHY, plus the CMD pin
interface cmd_phy_serdes_if;
  logic         iStrobe_in;
  logic [39:0]  iCmd_in;
  logic         iResponse_enable;
  logic         iLong_response;
  logic         iAck_in;
  logic         iIdle_in;
  logic         iCmd_pin_in;
  logic         oCmd_pin_out;
  logic         oCmd_pin_oe;
  logic         oSerial_ready;
  logic         oAck_out;
  logic         oStrobe_out;
  logic [135:0] oCmd_out;
  logic         oTimeout;
  logic         oCrc_error;
  modport master (
    output iStrobe_in, iCmd_in, iResponse_enable, iLong_response, iAck_in, iIdle_in, iCmd_pin_in,
    input  oCmd_pin_out, oCmd_pin_oe, oSerial_ready, oAck_out, oStrobe_out, oCmd_out, oTimeout, oCrc_error
  );
  modport slave (
    input  iStrobe_in, iCmd_in, iResponse_enable, iLong_response, iAck_in, iIdle_in, iCmd_pin_in,
    output oCmd_pin_out, oCmd_pin_oe, oSerial_ready, oAck_out, oStrobe_out, oCmd_out, oTimeout, oCrc_error
  );
endinterface

// File: rtl/cmd_phy_serdes.sv
// cmd_phy_serdes: SD CMD-line serializer with CRC7 append, response capture, CRC check and result handshake
module cmd_phy_serdes #(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int NCC_CYCLES     = 8
) (
  input logic            iClock_SD_Host,
  input logic            iReset,
  cmd_phy_serdes_if.slave bus
);
  typedef enum logic [2:0] {IDLE, SEND, WAIT_START, RECEIVE, CHECK, RESULT, GAP} state_t;
  state_t state_q, state_d;
  logic [15:0]  cnt_q, cnt_d;
  logic [47:0]  tx_q, tx_d;
  logic [135:0] rx_q, rx_d, out_q, out_d;
  logic resp_q, resp_d, long_q, long_d, pin_q, pin_d, oe_q, oe_d, ready_q, ready_d;
  logic ack_q, ack_d, strobe_q, strobe_d, to_q, to_d, crce_q, crce_d;
  logic [47:0] frame;
  logic        rx_bad;
  // Leading zeros leave a zero-init CRC unchanged, so one 120-bit walker serves both frame lengths
  function automatic logic [6:0] crc7(input logic [119:0] d);
    logic [6:0] c;
    c = '0;
    for (int i = 119; i >= 0; i--) c = {c[5:0], 1'b0} ^ ({7{c[6] ^ d[i]}} & 7'h09);
    return c;
  endfunction
  assign frame  = {bus.iCmd_in, crc7({80'b0, bus.iCmd_in}), 1'b1};
  assign rx_bad = (crc7(rx_q[127:8]) != rx_q[7:1]) || !rx_q[0];
  assign bus.oCmd_pin_out  = pin_q;
  assign bus.oCmd_pin_oe   = oe_q;
  assign bus.oSerial_ready = ready_q;
  assign bus.oAck_out      = ack_q;
  assign bus.oStrobe_out   = strobe_q;
  assign bus.oCmd_out      = out_q;
  assign bus.oTimeout      = to_q;
  assign bus.oCrc_error    = crce_q;
  // Next state and next registered outputs; abort overrides everything at the end
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + 16'd1;
    tx_d     = tx_q;
    rx_d     = rx_q;
    resp_d   = resp_q;
    long_d   = long_q;
    pin_d    = 1'b1;
    oe_d     = 1'b0;
    ready_d  = 1'b0;
    ack_d    = 1'b0;
    strobe_d = strobe_q;
    out_d    = out_q;
    to_d     = to_q;
    crce_d   = crce_q;
    case (state_q)
      IDLE: begin
        ready_d = !bus.iStrobe_in;
        cnt_d   = '0;
        if (bus.iStrobe_in) begin
          state_d = SEND;
          pin_d   = frame[47];
          tx_d    = {frame[46:0], 1'b1};
          oe_d    = 1'b1;
          ack_d   = 1'b1;
          resp_d  = bus.iResponse_enable;
          long_d  = bus.iLong_response;
        end
      end
      SEND: begin
        if (cnt_q == 16'd47) begin
          state_d  = resp_q ? WAIT_START : RESULT;
          cnt_d    = '0;
          strobe_d = !resp_q;
          to_d     = 1'b0;
          crce_d   = 1'b0;
        end else begin
          pin_d = tx_q[47];
          tx_d  = {tx_q[46:0], 1'b1};
          oe_d  = 1'b1;
        end
      end
      WAIT_START: begin
        if (cnt_q >= 16'd2 && !bus.iCmd_pin_in) begin
          state_d = RECEIVE;
          rx_d    = '0;
          cnt_d   = 16'd1;
        end else if (cnt_q == 16'(TIMEOUT_CYCLES - 1)) begin
          state_d  = RESULT;
          strobe_d = 1'b1;
          to_d     = 1'b1;
          crce_d   = 1'b0;
        end
      end
      RECEIVE: begin
        rx_d = {rx_q[134:0], bus.iCmd_pin_in};
        if (cnt_q == (long_q ? 16'd135 : 16'd47)) state_d = CHECK;
      end
      CHECK: begin
        state_d  = RESULT;
        strobe_d = 1'b1;
        to_d     = 1'b0;
        crce_d   = rx_bad;
        out_d    = rx_q;
      end
      RESULT: begin
        if (bus.iAck_in) begin
          state_d  = GAP;
          cnt_d    = '0;
          strobe_d = 1'b0;
          to_d     = 1'b0;
          crce_d   = 1'b0;
        end
      end
      GAP: begin
        state_d = (cnt_q == 16'(NCC_CYCLES - 1)) ? IDLE : GAP;
        ready_d = (cnt_q == 16'(NCC_CYCLES - 1));
      end
      default: state_d = IDLE;
    endcase
    if (bus.iIdle_in) begin
      state_d  = IDLE;
      cnt_d    = '0;
      pin_d    = 1'b1;
      oe_d     = 1'b0;
      ready_d  = 1'b1;
      ack_d    = 1'b0;
      strobe_d = 1'b0;
      to_d     = 1'b0;
      crce_d   = 1'b0;
    end
  end
  // FSM state register
  always_ff @(posedge iClock_SD_Host) begin
    if (iReset) state_q <= IDLE;
    else        state_q <= state_d;
  end
  // Datapath and registered outputs
  always_ff @(posedge iClock_SD_Host) begin
    if (iReset) begin
      cnt_q    <= '0;
      tx_q     <= '1;
      rx_q     <= '0;
      resp_q   <= 1'b0;
      long_q   <= 1'b0;
      pin_q    <= 1'b1;
      oe_q     <= 1'b0;
      ready_q  <= 1'b1;
      ack_q    <= 1'b0;
      strobe_q <= 1'b0;
      out_q    <= '0;
      to_q     <= 1'b0;
      crce_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      resp_q   <= resp_d;
      long_q   <= long_d;
      pin_q    <= pin_d;
      oe_q     <= oe_d;
      ready_q  <= ready_d;
      ack_q    <= ack_d;
      strobe_q <= strobe_d;
      out_q    <= out_d;
      to_q     <= to_d;
      crce_q   <= crce_d;
    end
  end
endmodule

// File: tb/tb_cmd_phy_serdes.sv
// tb_cmd_phy_serdes: randomized command/response traffic checked against a polynomial-division reference model
module tb_cmd_phy_serdes;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [135:0] exp_out = '0;
  always #5 clk = ~clk;
  cmd_phy_serdes_if bus();
  cmd_phy_serdes #(.TIMEOUT_CYCLES(64), .NCC_CYCLES(8)) dut (
    .iClock_SD_Host(clk),
    .iReset(rst),
    .bus(bus)
  );
  function automatic logic [6:0] crcref(input logic [119:0] d);
    logic [126:0] m;
    m = {d, 7'b0};
    for (int i = 126; i >= 7; i--) if (m[i]) m[i-:8] = m[i-:8] ^ 8'h89;
    return m[6:0];
  endfunction
  task automatic chk(input string tag, input logic [135:0] got, input logic [135:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic txn(input logic [39:0] cmd, input bit re, input bit lg, input logic [135:0] rf,
                     input int dly, input bit glitch, output logic [47:0] fr);
    logic [47:0] ef;
    logic oe_ok, hold_ok, exp_err;
    int k, n;
    ef = {cmd, crcref({80'b0, cmd}), 1'b1};
    chk("ready_pre", bus.oSerial_ready, 1);
    bus.iCmd_in = cmd;
    bus.iResponse_enable = re;
    bus.iLong_response = lg;
    bus.iStrobe_in = 1'b1;
    step();
    bus.iStrobe_in = 1'b0;
    bus.iCmd_in = {$urandom, 8'($urandom)};
    bus.iResponse_enable = !re;
    bus.iLong_response = !lg;
    chk("ack_pulse", bus.oAck_out, 1);
    fr = '0;
    oe_ok = 1'b1;
    for (int i = 47; i >= 0; i--) begin
      if (i == 46) chk("ack_single", bus.oAck_out, 0);
      fr[i] = bus.oCmd_pin_out;
      oe_ok &= bus.oCmd_pin_oe;
      step();
    end
    chk("frame", fr, ef);
    chk("oe_send", oe_ok, 1);
    chk("oe_release", {bus.oCmd_pin_oe, bus.oCmd_pin_out}, 2'b01);
    if (!re) begin
      chk("noresp_strobe", bus.oStrobe_out, 1);
      chk("noresp_flags", {bus.oTimeout, bus.oCrc_error}, 0);
      chk("noresp_out", bus.oCmd_out, exp_out);
    end else if (dly < 0) begin
      k = 0;
      while (!bus.oStrobe_out && k < 200) begin
        step();
        k++;
      end
      chk("timeout_latency", k, 64);
      chk("timeout_flags", {bus.oTimeout, bus.oCrc_error}, 2'b10);
    end else begin
      for (int i = 0; i < dly; i++) begin
        bus.iCmd_pin_in = !(glitch && i < 2);
        step();
      end
      n = lg ? 136 : 48;
      for (int i = n - 1; i >= 0; i--) begin
        bus.iCmd_pin_in = rf[i];
        step();
      end
      bus.iCmd_pin_in = 1'b1;
      chk("check_no_strobe", bus.oStrobe_out, 0);
      step();
      exp_out = lg ? rf : {88'b0, rf[47:0]};
      exp_err = lg ? ((crcref(rf[127:8]) != rf[7:1]) || !rf[0])
                   : ((crcref({80'b0, rf[47:8]}) != rf[7:1]) || !rf[0]);
      chk("resp_strobe", bus.oStrobe_out, 1);
      chk("resp_out", bus.oCmd_out, exp_out);
      chk("resp_flags", {bus.oTimeout, bus.oCrc_error}, {1'b0, exp_err});
    end
    k = $urandom_range(0, 3);
    hold_ok = 1'b1;
    for (int i = 0; i < k; i++) begin
      step();
      hold_ok &= bus.oStrobe_out;
    end
    chk("strobe_hold", hold_ok, 1);
    bus.iAck_in = 1'b1;
    step();
    bus.iAck_in = 1'b0;
    chk("ack_clears", {bus.oStrobe_out, bus.oTimeout, bus.oCrc_error}, 0);
    k = 0;
    while (!bus.oSerial_ready && k < 50) begin
      step();
      k++;
    end
    chk("gap_len", k, 8);
  endtask
  initial begin
    logic [47:0] fr;
    logic [39:0] cmd;
    logic [135:0] r;
    logic [127:0] rnd;
    int kind;
    bus.iStrobe_in = 1'b0;
    bus.iCmd_in = '0;
    bus.iResponse_enable = 1'b0;
    bus.iLong_response = 1'b0;
    bus.iAck_in = 1'b0;
    bus.iIdle_in = 1'b0;
    bus.iCmd_pin_in = 1'b1;
    repeat (3) step();
    chk("reset_pin", {bus.oCmd_pin_out, bus.oCmd_pin_oe, bus.oSerial_ready, bus.oAck_out}, 4'b1010);
    chk("reset_flags", {bus.oStrobe_out, bus.oTimeout, bus.oCrc_error}, 0);
    chk("reset_out", bus.oCmd_out, 0);
    rst = 1'b0;
    step();
    txn(40'h4000000000, 0, 0, '0, 0, 0, fr);
    chk("cmd0_const", fr, 48'h400000000095);
    txn(40'h48000001AA, 0, 0, '0, 0, 0, fr);
    chk("cmd8_const", fr, 48'h48000001AA87);
    txn(40'h5100000000, 0, 0, '0, 0, 0, fr);
    chk("cmd17_const", fr, 48'h510000000055);
    txn(40'h4D00000000, 1, 0, 136'h400000000095, 5, 0, fr);
    chk("short_ok_err", bus.oCmd_out, 136'h400000000095);
    txn(40'h4D00000000, 1, 0, 136'h400000000097, 5, 0, fr);
    txn(40'h4D00000000, 1, 0, 136'h400000000095, 2, 0, fr);
    txn(40'h4D00000000, 1, 0, 136'h400000000095, 6, 1, fr);
    txn(40'h4D00000000, 1, 0, '0, -1, 0, fr);
    txn(40'h69003C0000, 1, 0, 136'h3F00FF8000FF, 4, 0, fr);
    rnd = {$urandom, $urandom, $urandom, $urandom};
    r = {8'h3F, rnd[119:0], 8'h00};
    r[7:1] = crcref(r[127:8]);
    r[0] = 1'b1;
    txn(40'h4200000000, 1, 1, r, 7, 0, fr);
    r[0] = 1'b0;
    txn(40'h4200000000, 1, 1, r, 7, 0, fr);
    for (int it = 0; it < 20; it++) begin
      cmd = {2'b01, 6'($urandom), 32'($urandom)};
      kind = $urandom_range(0, 5);
      rnd = {$urandom, $urandom, $urandom, $urandom};
      if (kind <= 2) begin
        r = {88'b0, 2'b00, rnd[37:0], 8'h00};
        r[7:1] = crcref({80'b0, r[47:8]});
        r[0] = 1'b1;
        if (kind == 2) r[$urandom_range(0, 46)] ^= 1'b1;
      end else begin
        r = {8'h3F, rnd[119:0], 8'h00};
        r[7:1] = crcref(r[127:8]);
        r[0] = (kind != 4);
      end
      txn(cmd, kind != 5, kind >= 3, r, $urandom_range(2, 40), 0, fr);
    end
    bus.iCmd_in = 40'h5100000000;
    bus.iResponse_enable = 1'b1;
    bus.iStrobe_in = 1'b1;
    step();
    bus.iStrobe_in = 1'b0;
    repeat (27) step();
    bus.iIdle_in = 1'b1;
    step();
    bus.iIdle_in = 1'b0;
    chk("abort_oe", {bus.oCmd_pin_oe, bus.oCmd_pin_out, bus.oSerial_ready}, 3'b011);
    chk("abort_flags", {bus.oStrobe_out, bus.oAck_out, bus.oTimeout, bus.oCrc_error}, 0);
    chk("abort_out_kept", bus.oCmd_out, exp_out);
    bus.iCmd_in = 40'h5100000000;
    bus.iResponse_enable = 1'b1;
    bus.iLong_response = 1'b1;
    bus.iStrobe_in = 1'b1;
    step();
    bus.iStrobe_in = 1'b0;
    repeat (48) step();
    repeat (5) step();
    for (int i = 0; i < 20; i++) begin
      bus.iCmd_pin_in = (i == 0) ? 1'b0 : 1'($urandom);
      step();
    end
    rst = 1'b1;
    bus.iCmd_pin_in = 1'b1;
    step();
    rst = 1'b0;
    exp_out = '0;
    chk("rst_mid_pin", {bus.oCmd_pin_out, bus.oCmd_pin_oe, bus.oSerial_ready, bus.oAck_out}, 4'b1010);
    chk("rst_mid_flags", {bus.oStrobe_out, bus.oTimeout, bus.oCrc_error}, 0);
    chk("rst_mid_out", bus.oCmd_out, 0);
    txn(40'h4000000000, 0, 0, '0, 0, 0, fr);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/cmd_phy_serdes.md
# cmd_phy_serdes

SD host CMD-line physical layer: sits directly downstream of the command control FSM. It accepts a 40-bit command frame body, appends CRC7 and the end bit, and shifts the 48-bit frame onto the CMD pin MSB-first. It then optionally captures a 48- or 136-bit response, checks it, and hands it back through a strobe/ack handshake. Everything runs on the SD host clock, one bit per clock.

## Interface
Parameters:
- TIMEOUT_CYCLES, 64, response start-bit window in clocks (NCR limit)
- NCC_CYCLES, 8, idle gap enforced after each transaction

Ports:
- iClock_SD_Host  in  1  SD host clock, all logic on rising edge
- iReset  in  1  synchronous, active-high reset
- iStrobe_in  in  1  new command valid (from control oStrobe_out)
- iCmd_in  in  40  {start=0, trans=1, index[5:0], argument[31:0]}
- iResponse_enable  in  1  response expected; sampled with accepted strobe
- iLong_response  in  1  1 = 136-bit (R2), 0 = 48-bit; sampled with accepted strobe
- iAck_in  in  1  control has consumed the response
- iIdle_in  in  1  abort: force IDLE
- iCmd_pin_in  in  1  sampled CMD line
- oCmd_pin_out  out  1  CMD line drive value
- oCmd_pin_oe  out  1  CMD output enable
- oSerial_ready  out  1  idle, may accept a command
- oAck_out  out  1  one-cycle pulse: command accepted
- oStrobe_out  out  1  transaction result valid, held until iAck_in
- oCmd_out  out  136  received response, right-aligned, MSB first
- oTimeout  out  1  no start bit within TIMEOUT_CYCLES
- oCrc_error  out  1  CRC7 mismatch or end bit 0

## Operation
States: IDLE, SEND, WAIT_START, RECEIVE, CHECK, RESULT, GAP.
- IDLE: oSerial_ready=1. iStrobe_in=1 -> latch frame and response flags, pulse oAck_out, go to SEND.
- SEND: 48 cycles. Bits 47..8 come from the latched frame. CRC7 (x^7+x^3+1, zero init) is computed serially over bits 47..8. CRC is sent as bits 7..1. Bit 0 is 1. oe=1 throughout. Next state: WAIT_START if a response is enabled, else RESULT with all flags 0 and oCmd_out unchanged.
- WAIT_START: oe=0. A counter runs from 0 at entry. iCmd_pin_in is ignored while count<2 (line release). A low sample at count>=2 is the start bit: capture it as frame MSB and go to RECEIVE. Count reaching TIMEOUT_CYCLES: oTimeout=1, go to RESULT.
- RECEIVE: shift in the remaining 47 or 135 bits.
- CHECK: one cycle.
  - 48-bit frames: CRC over received bits 47..8, compared with bits 7..1.
  - 136-bit frames: CRC over bits 127..8, compared with bits 7..1.
  - Mismatch or bit 0 = 0 sets oCrc_error.
  - Load oCmd_out; upper bits are zeroed for 48-bit frames.
- RESULT: oStrobe_out=1 with flags stable. On iAck_in: clear strobe and flags, go to GAP.
- GAP: oe=0, line high, NCC_CYCLES clocks, then IDLE.
- iIdle_in=1 in any state: next state IDLE, oe=0, strobe and flags cleared, no oAck_out. oCmd_out is retained.
- iStrobe_in outside IDLE is ignored.
- R3-type frames (CRC field all ones) raise oCrc_error. Control decides whether to honour it.

## Timing
- Reset values: oCmd_pin_out=1, oCmd_pin_oe=0, oSerial_ready=1, oAck_out=0, oStrobe_out=0, oCmd_out=0, oTimeout=0, oCrc_error=0. State=IDLE.
- Strobe accepted at edge T: oAck_out=1 and frame bit 47 on pin during cycle T+1. Bit 0 at T+48. oe falls at T+49.
- All outputs are registered. oCmd_pin_out=1 whenever oe=0.
- Response of N bits whose start bit is sampled at edge S: last bit at S+N-1, CHECK at S+N, oStrobe_out=1 at S+N+1.
- iAck_in in the same cycle strobe rises is honoured.
- No-response command: oStrobe_out rises at T+49.
- Minimum command-to-command spacing after ack: NCC_CYCLES+1 clocks.

## Test plan
- CMD0, iCmd_in=0x4000000000, no response -> pin carries 0x400000000095 over 48 cycles, oAck_out pulse at T+1, oStrobe_out at T+49 with flags 0.
- CMD8, arg 0x1AA -> pin carries 0x48000001AA87. CMD17 arg 0 -> 0x510000000055.
- Short response: bench drives 0x400000000095 starting 5 clocks after release -> oCmd_out[47:0]=0x400000000095, upper bits 0, oCrc_error=0. Repeat with 0x400000000097 -> oCrc_error=1.
- Line held high, TIMEOUT_CYCLES=64 -> oTimeout=1 and strobe exactly 64 clocks after WAIT_START entry. Then ack -> GAP of 8 clocks -> oSerial_ready=1.
- Long response of 136 bits with valid CRC over bits 127..8 -> full oCmd_out match, no error. Same stimulus with end bit 0 -> oCrc_error=1.
- iIdle_in asserted at bit 20 of SEND -> oe=0 next cycle, oSerial_ready=1, no strobe. iReset mid-RECEIVE -> all reset values next cycle.
